// File: rtl/counter_pkg.sv
// Shared definitions for the counter/timebase blocks.
//   DIR_DOWN / DIR_UP : encoding of the up_dn direction input
//   presc_width(div)  : register width for a 0..div-1 prescaler (at least 1)
package counter_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  function automatic int presc_width(input int div);
    return ($clog2(div) < 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock-enable prescaler: emits a one-cycle tick every DIV enabled clk cycles.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, presc -> 0
//   en   : advance enable; presc holds when low
//   clr  : synchronous clear of presc (wins over en)
//   tick : combinational strobe, en && presc == DIV-1 (forced low in reset)
module tick_gen
  import counter_pkg::*;
#(
  parameter int DIV = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = presc_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (en) begin
      if (presc == LAST) presc <= '0;
      else               presc <= presc + 1'b1;
    end
  end

  // For DIV=1 presc is constantly 0, so the !rst term is what keeps tick
  // low during reset; for larger DIV it is redundant but harmless.
  assign tick = en && (presc == LAST) && !rst;

endmodule

// File: rtl/prescaled_counter.sv
// Modulo up/down counter stepped by an internal prescaler tick.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset (out=0, presc=0, wrap=0)
//   en       : prescaler enable
//   up_dn    : direction, 1 = up, 0 = down, sampled on tick cycles
//   clr      : synchronous clear of counter and prescaler
//   load     : synchronous parallel load (clamped to MODULO-1)
//   load_val : value to load
//   out      : registered count, 0..MODULO-1
//   tick     : combinational step strobe
//   wrap     : registered one-cycle pulse when out wraps around
module prescaled_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10,
  parameter int DIV    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  // One extra bit so MODULO = 2**WIDTH is representable in the clamp compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  logic [WIDTH-1:0] load_clamped;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clr),
    .tick (tick)
  );

  assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      out  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      out  <= load_clamped;
      wrap <= 1'b0;
    end else if (tick) begin
      if (up_dn == DIR_UP) begin
        if (out == MAX_VAL) begin
          out  <= '0;
          wrap <= 1'b1;
        end else begin
          out  <= out + 1'b1;
          wrap <= 1'b0;
        end
      end else begin
        if (out == '0) begin
          out  <= MAX_VAL;
          wrap <= 1'b1;
        end else begin
          out  <= out - 1'b1;
          wrap <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prescaled_counter.sv
module tb_prescaled_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // main instance: WIDTH=4, MODULO=10, DIV=5
  logic       en = 0, up_dn = 1, clr = 0, load = 0;
  logic [3:0] load_val = 0;
  logic [3:0] out;
  logic       tick, wrap;

  prescaled_counter #(.WIDTH(4), .MODULO(10), .DIV(5)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .out(out), .tick(tick), .wrap(wrap)
  );

  // full range instance: WIDTH=4, MODULO=16, DIV=1
  logic       en2 = 0, up_dn2 = 1, clr2 = 0, load2 = 0;
  logic [3:0] load_val2 = 0;
  logic [3:0] out2;
  logic       tick2, wrap2;

  prescaled_counter #(.WIDTH(4), .MODULO(16), .DIV(1)) dut_fr (
    .clk(clk), .rst(rst), .en(en2), .up_dn(up_dn2), .clr(clr2), .load(load2),
    .load_val(load_val2), .out(out2), .tick(tick2), .wrap(wrap2)
  );

  // cascade: units MODULO=10 DIV=10, tens MODULO=6 DIV=1 enabled by units.wrap
  logic       en_u = 0;
  logic [3:0] out_u;
  logic       tick_u, wrap_u;
  logic [2:0] out_t;
  logic       tick_t, wrap_t;

  prescaled_counter #(.WIDTH(4), .MODULO(10), .DIV(10)) dut_u (
    .clk(clk), .rst(rst), .en(en_u), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .out(out_u), .tick(tick_u), .wrap(wrap_u)
  );

  prescaled_counter #(.WIDTH(3), .MODULO(6), .DIV(1)) dut_t (
    .clk(clk), .rst(rst), .en(wrap_u), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(3'd0), .out(out_t), .tick(tick_t), .wrap(wrap_t)
  );

  // advance one rising edge, leave time 1 unit after it for drive/sample
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en2 = 1;
    #3;
    total++; if (out !== 4'd0) begin bad++; $display("FAIL reset_out got=%0d exp=0", out); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%0b exp=0", wrap); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%0b exp=0", tick); end
    total++; if (tick2 !== 1'b0) begin bad++; $display("FAIL reset_tick_div1 got=%0b exp=0", tick2); end
    en2 = 0;
    step();
    rst = 0;
    step();
  endtask

  task automatic test_up();
    en = 1; up_dn = 1;
    repeat (4) step();
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL up_tick_pre got=%0b exp=1", tick); end
    total++; if (out !== 4'd0) begin bad++; $display("FAIL up_out_pre got=%0d exp=0", out); end
    step();
    total++; if (out !== 4'd1) begin bad++; $display("FAIL up_first_step got=%0d exp=1", out); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL up_tick_post got=%0b exp=0", tick); end
    for (int k = 2; k <= 10; k++) begin
      repeat (4) step();
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL up_wrap_idle k=%0d got=%0b exp=0", k, wrap); end
      step();
      total++; if (out !== 4'(k % 10)) begin bad++; $display("FAIL up_seq k=%0d got=%0d exp=%0d", k, out, k % 10); end
      total++; if (wrap !== (k == 10)) begin bad++; $display("FAIL up_wrap k=%0d got=%0b exp=%0b", k, wrap, k == 10); end
    end
    step();
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL up_wrap_one_cycle got=%0b exp=0", wrap); end
    // 34 more edges (one already spent) bring the count to 7
    repeat (34) step();
    total++; if (out !== 4'd7) begin bad++; $display("FAIL up_reach7 got=%0d exp=7", out); end
  endtask

  task automatic test_reset_mid();
    #2 rst = 1;
    #1;
    total++; if (out !== 4'd0) begin bad++; $display("FAIL rstmid_out got=%0d exp=0", out); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL rstmid_wrap got=%0b exp=0", wrap); end
    total++; if (dut.u_tick.presc !== 3'd0) begin bad++; $display("FAIL rstmid_presc got=%0d exp=0", dut.u_tick.presc); end
    step();
    rst = 0; en = 0;
    repeat (20) step();
    total++; if (out !== 4'd0) begin bad++; $display("FAIL hold_en0 got=%0d exp=0", out); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL hold_tick got=%0b exp=0", tick); end
    // first step lands on the 5th enabled edge after release
    en = 1; up_dn = 1;
    repeat (4) step();
    total++; if (out !== 4'd0) begin bad++; $display("FAIL post_rst_early got=%0d exp=0", out); end
    step();
    total++; if (out !== 4'd1) begin bad++; $display("FAIL post_rst_first got=%0d exp=1", out); end
  endtask

  task automatic test_down();
    clr = 1; step(); clr = 0;
    total++; if (out !== 4'd0) begin bad++; $display("FAIL clr_out got=%0d exp=0", out); end
    up_dn = 0; en = 1;
    repeat (5) step();
    total++; if (out !== 4'd9) begin bad++; $display("FAIL down_first got=%0d exp=9", out); end
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL down_wrap got=%0b exp=1", wrap); end
    repeat (5) step();
    total++; if (out !== 4'd8) begin bad++; $display("FAIL down_8 got=%0d exp=8", out); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL down_wrap_clr got=%0b exp=0", wrap); end
    up_dn = 1;  // direction change takes effect on the next tick
    repeat (5) step();
    total++; if (out !== 4'd9) begin bad++; $display("FAIL dir_change got=%0d exp=9", out); end
  endtask

  task automatic test_load();
    en = 0;
    load = 1; load_val = 4'd12; step();
    total++; if (out !== 4'd9) begin bad++; $display("FAIL load_clamp12 got=%0d exp=9", out); end
    load_val = 4'd10; step();
    total++; if (out !== 4'd9) begin bad++; $display("FAIL load_clamp10 got=%0d exp=9", out); end
    load_val = 4'd6; step();
    total++; if (out !== 4'd6) begin bad++; $display("FAIL load_6 got=%0d exp=6", out); end
    load = 0;
    clr = 1; en = 1; step(); clr = 0;
    up_dn = 1;
    repeat (4) step();
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL load_tick_setup got=%0b exp=1", tick); end
    load = 1; load_val = 4'd3; step(); load = 0;
    total++; if (out !== 4'd3) begin bad++; $display("FAIL load_beats_tick got=%0d exp=3", out); end
    total++; if (dut.u_tick.presc !== 3'd0) begin bad++; $display("FAIL load_presc_adv got=%0d exp=0", dut.u_tick.presc); end
    repeat (2) step();
    clr = 1; load = 1; load_val = 4'd5; step(); clr = 0; load = 0;
    total++; if (out !== 4'd0) begin bad++; $display("FAIL clr_over_load got=%0d exp=0", out); end
    total++; if (dut.u_tick.presc !== 3'd0) begin bad++; $display("FAIL clr_presc got=%0d exp=0", dut.u_tick.presc); end
    en = 0;
  endtask

  task automatic test_full_range();
    en2 = 0; #1;
    total++; if (tick2 !== 1'b0) begin bad++; $display("FAIL fr_tick_en0 got=%0b exp=0", tick2); end
    load2 = 1; load_val2 = 4'd15; step(); load2 = 0;
    total++; if (out2 !== 4'd15) begin bad++; $display("FAIL fr_load15 got=%0d exp=15", out2); end
    en2 = 1; up_dn2 = 1; #1;
    total++; if (tick2 !== 1'b1) begin bad++; $display("FAIL fr_tick_en1 got=%0b exp=1", tick2); end
    step();
    total++; if (out2 !== 4'd0 || wrap2 !== 1'b1) begin bad++; $display("FAIL fr_up_wrap got=%0d/%0b exp=0/1", out2, wrap2); end
    up_dn2 = 0; step();
    total++; if (out2 !== 4'd15 || wrap2 !== 1'b1) begin bad++; $display("FAIL fr_down_wrap got=%0d/%0b exp=15/1", out2, wrap2); end
    step();
    total++; if (out2 !== 4'd14 || wrap2 !== 1'b0) begin bad++; $display("FAIL fr_down_14 got=%0d/%0b exp=14/0", out2, wrap2); end
    en2 = 0;
  endtask

  task automatic test_cascade();
    int tens_wraps;
    tens_wraps = 0;
    rst = 1; #1; rst = 0;
    en_u = 1;
    for (int c = 1; c <= 601; c++) begin
      step();
      if (wrap_t) tens_wraps++;
      if (c == 301) begin
        total++; if (out_t !== 3'd3 || out_u !== 4'd0) begin bad++; $display("FAIL casc_mid got=%0d%0d exp=30", out_t, out_u); end
      end
    end
    total++; if (out_u !== 4'd0) begin bad++; $display("FAIL casc_units got=%0d exp=0", out_u); end
    total++; if (out_t !== 3'd0) begin bad++; $display("FAIL casc_tens got=%0d exp=0", out_t); end
    total++; if (wrap_t !== 1'b1) begin bad++; $display("FAIL casc_tens_wrap got=%0b exp=1", wrap_t); end
    total++; if (tens_wraps != 1) begin bad++; $display("FAIL casc_wrap_count got=%0d exp=1", tens_wraps); end
    en_u = 0;
  endtask

  initial begin
    test_reset();
    test_up();
    test_reset_mid();
    test_down();
    test_load();
    test_full_range();
    test_cascade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
